// File: rtl/event_monitor_pkg.sv
// Shared definitions for the event monitor slice.
//   evt_w()     - width of one captured event {ts, id, data}
//   nbeats()    - stream beats needed to carry one event
//   HDR_MAGIC   - top byte of the optional per-event header beat
//   drain_state_e - drain sequencer states
package event_monitor_pkg;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SEND
  } drain_state_e;

  function automatic int unsigned evt_w(input int unsigned ts_w,
                                        input int unsigned id_w,
                                        input int unsigned probe_w);
    return ts_w + id_w + probe_w;
  endfunction

  function automatic int unsigned nbeats(input int unsigned ew,
                                         input int unsigned out_w);
    return (ew + out_w - 1) / out_w;
  endfunction

endpackage

// File: rtl/event_drain_ctrl.sv
// Drains events from the core's show-ahead event FIFO and serializes each
// one into OUT_W-bit beats on a valid/ready stream, LSB beat first.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   drain_en       level; permits starting a new event drain
//   evt_valid      FIFO head valid (show-ahead)
//   evt_data       FIFO head {ts, id, data}
//   evt_pop        one-cycle pop pulse back to the FIFO
//   m_valid/m_ready/m_data/m_last   output stream, m_last on final beat
//   busy           high while not IDLE
//   evt_count      events fully sent since reset (wraps)
//
// Build option: define EVT_DRAIN_HDR_EN to precede every event with one
// header beat {HDR_MAGIC, NBEATS, seq[15:0]}.
module event_drain_ctrl
  import event_monitor_pkg::*;
#(
  parameter int unsigned PROBE_W = 32,
  parameter int unsigned ID_W    = 8,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned OUT_W   = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          drain_en,
  input  logic                          evt_valid,
  input  logic [TS_W+ID_W+PROBE_W-1:0]  evt_data,
  output logic                          evt_pop,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [OUT_W-1:0]              m_data,
  output logic                          m_last,
  output logic                          busy,
  output logic [CNT_W-1:0]              evt_count
);

  localparam int unsigned EVT_W = evt_w(TS_W, ID_W, PROBE_W);
  localparam int unsigned NB    = nbeats(EVT_W, OUT_W);
  localparam int unsigned SH_W  = NB * OUT_W;
  localparam int unsigned BC_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(NB - 1);

  drain_state_e          state, state_nx;
  logic [SH_W-1:0]       shift_reg;
  logic [BC_W-1:0]       beat_cnt;
  logic                  start;
  logic                  data_acc;
  logic                  last_acc;

`ifdef EVT_DRAIN_HDR_EN
  logic [15:0]           seq;
  logic [OUT_W-1:0]      hdr_word;
  logic                  hdr_acc;

  assign hdr_word = OUT_W'({HDR_MAGIC, 8'(NB), seq});
  assign hdr_acc  = (state == HDR) && m_ready;
`endif

  // Capture happens only from IDLE; the mandatory IDLE cycle between
  // events lets the FIFO head settle after the previous pop.
  assign start    = (state == IDLE) && drain_en && evt_valid;
  assign data_acc = (state == SEND) && m_ready;
  assign last_acc = data_acc && (beat_cnt == LAST_BEAT);

  always_comb begin
    state_nx = state;
    evt_pop  = 1'b0;
    m_valid  = 1'b0;
    m_data   = '0;
    m_last   = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          // Gated by rst_n so no pop can escape while the block is held in reset.
          evt_pop  = rst_n;
`ifdef EVT_DRAIN_HDR_EN
          state_nx = HDR;
`else
          state_nx = SEND;
`endif
        end
      end
`ifdef EVT_DRAIN_HDR_EN
      HDR: begin
        m_valid = 1'b1;
        m_data  = hdr_word;
        if (m_ready) state_nx = SEND;
      end
`endif
      SEND: begin
        m_valid = 1'b1;
        m_data  = shift_reg[OUT_W-1:0];
        m_last  = (beat_cnt == LAST_BEAT);
        if (last_acc) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      evt_count <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        shift_reg <= SH_W'(evt_data);
        beat_cnt  <= '0;
      end else if (data_acc) begin
        shift_reg <= shift_reg >> OUT_W;
        beat_cnt  <= beat_cnt + 1'b1;
      end
      if (last_acc) evt_count <= evt_count + 1'b1;
    end
  end

`ifdef EVT_DRAIN_HDR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= '0;
    end else if (hdr_acc) begin
      seq <= seq + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_event_drain_ctrl.sv
module tb_event_drain_ctrl;

  localparam int PROBE_W = 32;
  localparam int ID_W    = 8;
  localparam int TS_W    = 32;
  localparam int OUT_W   = 32;
  localparam int CNT_W   = 2;   // narrow so the wrap is reachable
  localparam int EVT_W   = TS_W + ID_W + PROBE_W;
  localparam int NB      = (EVT_W + OUT_W - 1) / OUT_W;
`ifdef EVT_DRAIN_HDR_EN
  localparam int NBT     = NB + 1;
`else
  localparam int NBT     = NB;
`endif

  logic              clk;
  logic              rst_n;
  logic              drain_en;
  logic              evt_valid;
  logic [EVT_W-1:0]  evt_data;
  logic              evt_pop;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic              m_last;
  logic              busy;
  logic [CNT_W-1:0]  evt_count;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t            exp_q[$];
  logic [EVT_W-1:0] fifo_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  int               hs_cnt = 0;
  int               pop_cnt = 0;
  int               cyc = 0;
  int               hs_cyc[$];
  bit               pend_pop = 0;
  logic [15:0]      seq_m = '0;
  bit               hold_vld = 0;
  logic [OUT_W-1:0] hold_data;
  logic             hold_last;

  event_drain_ctrl #(
    .PROBE_W(PROBE_W), .ID_W(ID_W), .TS_W(TS_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .drain_en(drain_en),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_pop(evt_pop),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .evt_count(evt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic refresh_fifo();
    evt_valid = (fifo_q.size() != 0);
    evt_data  = evt_valid ? fifo_q[0] : '0;
  endtask

  task automatic push_evt(input logic [EVT_W-1:0] ev);
    fifo_q.push_back(ev);
    refresh_fifo();
  endtask

  // Reference serialization of one popped event into expected beats.
  task automatic push_expected(input logic [EVT_W-1:0] ev);
    beat_t b;
    logic [NB*OUT_W-1:0] v;
`ifdef EVT_DRAIN_HDR_EN
    b.data = OUT_W'({8'hA5, 8'(NB), seq_m});
    b.last = 1'b0;
    exp_q.push_back(b);
    seq_m = seq_m + 16'd1;
`endif
    v = (NB*OUT_W)'(ev);
    for (int i = 0; i < NB; i++) begin
      b.data = v[i*OUT_W +: OUT_W];
      b.last = (i == NB - 1);
      exp_q.push_back(b);
    end
  endtask

  // FIFO model: a pop seen before an edge takes effect just after it.
  always @(posedge clk) begin
    cyc++;
    if (pend_pop) begin
      #1;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      pend_pop = 0;
      refresh_fifo();
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (evt_pop) begin
        n_cmp++;
        if (evt_valid !== 1'b1) begin
          n_err++;
          $display("FAIL pop_empty: evt_pop=1 with evt_valid=%b, required 1", evt_valid);
        end
        pend_pop = 1;
        pop_cnt++;
        push_expected(evt_data);
      end
      if (hold_vld) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== hold_data || m_last !== hold_last) begin
          n_err++;
          $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   m_valid, m_data, m_last, hold_data, hold_last);
        end
      end
      hold_vld = 0;
      if (m_valid === 1'b1) begin
        if (m_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL beat_unexpected: data=%h last=%b, required no beat", m_data, m_last);
          end else begin
            b = exp_q.pop_front();
            if (m_data !== b.data || m_last !== b.last) begin
              n_err++;
              $display("FAIL beat: data=%h last=%b, required data=%h last=%b",
                       m_data, m_last, b.data, b.last);
            end
          end
          hs_cnt++;
          hs_cyc.push_back(cyc);
        end else begin
          hold_vld  = 1;
          hold_data = m_data;
          hold_last = m_last;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int i;
    for (i = 0; i < budget && hs_cnt < target; i++) tick(1);
    n_cmp++;
    if (hs_cnt < target) begin
      n_err++;
      $display("FAIL %s_timeout: handshakes=%0d, required %0d", name, hs_cnt, target);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    drain_en = 1'b0;
    m_ready  = 1'b0;
    fifo_q.delete();
    refresh_fifo();
    exp_q.delete();
    hs_cyc.delete();
    hold_vld = 0;
    pend_pop = 0;
    seq_m    = '0;
    hs_cnt   = 0;
    pop_cnt  = 0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic check_count(input int exp, input string name);
    n_cmp++;
    if (evt_count !== CNT_W'(exp)) begin
      n_err++;
      $display("FAIL %s: evt_count=%0d, required %0d", name, evt_count, CNT_W'(exp));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drain_en = 1'b0;
    m_ready = 1'b0;
    refresh_fifo();
    #1;
    n_cmp++;
    if ({evt_pop, m_valid, m_last, busy} !== 4'b0 || m_data !== '0 || evt_count !== '0) begin
      n_err++;
      $display("FAIL reset_values: pop=%b valid=%b data=%h last=%b busy=%b count=%0d, required all 0",
               evt_pop, m_valid, m_data, m_last, busy, evt_count);
    end
    do_reset();
    drain_en = 1'b1;
    m_ready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_cmp++;
      if ({evt_pop, m_valid, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL empty_idle: pop=%b valid=%b busy=%b, required 000", evt_pop, m_valid, busy);
      end
    end
    check_count(0, "empty_count");
  endtask

  task automatic test_single();
    do_reset();
    drain_en = 1'b1;
    m_ready  = 1'b1;
    push_evt({32'h0000_1234, 8'h5A, 32'hDEAD_BEEF});
    wait_hs(NBT, 50, "single");
    tick(2);
    n_cmp++;
    if (pop_cnt !== 1) begin
      n_err++;
      $display("FAIL single_pops: pops=%0d, required 1", pop_cnt);
    end
    n_cmp++;
    if (hs_cyc.size() != NBT || hs_cyc[NBT-1] - hs_cyc[0] !== NBT - 1) begin
      n_err++;
      $display("FAIL single_consecutive: beats=%0d span=%0d, required %0d beats span %0d",
               hs_cyc.size(), (hs_cyc.size() != 0) ? hs_cyc[hs_cyc.size()-1] - hs_cyc[0] : -1,
               NBT, NBT - 1);
    end
    check_count(1, "single_count");
  endtask

  task automatic test_backpressure();
    logic pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int i;
    do_reset();
    drain_en = 1'b1;
    m_ready  = 1'b0;
    push_evt({32'hCAFE_0001, 8'h3C, 32'h1357_9BDF});
    for (i = 0; i < 20 && busy !== 1'b1; i++) tick(1);
    foreach (pat[k]) begin
      m_ready = pat[k];
      tick(1);
    end
    m_ready = 1'b1;
    wait_hs(NBT, 50, "bp");
    tick(3);
    n_cmp++;
    if (hs_cnt !== NBT || pop_cnt !== 1) begin
      n_err++;
      $display("FAIL bp_counts: handshakes=%0d pops=%0d, required %0d and 1", hs_cnt, pop_cnt, NBT);
    end
    check_count(1, "bp_count");
  endtask

  task automatic test_drain_stop();
    do_reset();
    for (int i = 0; i < 3; i++) push_evt({$urandom(), 8'($urandom()), $urandom()});
    drain_en = 1'b1;
    m_ready  = 1'b1;
    wait_hs(NBT + 1, 50, "stop_mid");
    drain_en = 1'b0;
    wait_hs(2 * NBT, 50, "stop_end");
    tick(10);
    n_cmp++;
    if (pop_cnt !== 2 || fifo_q.size() != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stop_pops: pops=%0d fifo=%0d pending=%0d, required 2, 1, 0",
               pop_cnt, fifo_q.size(), exp_q.size());
    end
    check_count(2, "stop_count");
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_evt({32'h1111_2222, 8'h33, 32'h4444_5555});
    push_evt({32'h6666_7777, 8'h88, 32'h9999_AAAA});
    drain_en = 1'b1;
    m_ready  = 1'b1;
    wait_hs(1, 50, "rmid_start");
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, busy, evt_pop} !== 3'b000) begin
      n_err++;
      $display("FAIL rmid_async: valid=%b busy=%b pop=%b, required 000", m_valid, busy, evt_pop);
    end
    exp_q.delete();
    hold_vld = 0;
    seq_m = '0;
    hs_cnt = 0;
    tick(2);
    rst_n = 1'b1;
    wait_hs(NBT, 50, "rmid_next");
    tick(3);
    n_cmp++;
    if (fifo_q.size() != 0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL rmid_fifo: fifo=%0d pending=%0d, required 0 and 0", fifo_q.size(), exp_q.size());
    end
    check_count(1, "rmid_count");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) push_evt({$urandom(), 8'($urandom()), $urandom()});
    drain_en = 1'b1;
    m_ready  = 1'b1;
    wait_hs(5 * NBT, 200, "wrap");
    tick(3);
    check_count(5 % (1 << CNT_W), "wrap_count");
  endtask

  initial begin
    rst_n = 1'b0;
    drain_en = 1'b0;
    m_ready = 1'b0;
    evt_valid = 1'b0;
    evt_data = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_drain_stop();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
